// File: rtl/vote_argmax_pkg.sv
// Shared definitions for the vote arg-max block: packing macros for flattened
// counter vectors and the scan FSM state encoding.
`ifndef VOTE_ARGMAX_PKG_MACROS
`define VOTE_ARGMAX_PKG_MACROS
`define PORT_1D(name, dim, w) logic [(dim)*(w)-1:0] name
`define GET_1D(src, i, w) src[(i)*(w) +: (w)]
`endif

package vote_argmax_pkg;

  localparam int VA_OUTPUT_DIM      = 10;
  localparam int VA_W_BITLENGTH     = 12;
  localparam int VA_CLASS_BITLENGTH = 4;

  typedef enum logic [1:0] {
    VA_IDLE = 2'd0,
    VA_SCAN = 2'd1,
    VA_HOLD = 2'd2
  } va_state_t;

endpackage

// File: rtl/vote_rank_update.sv
// Combinational best/second-best update for one vote counter.
// Strict compares keep the lower index on ties; a tie with best lands in second.
module vote_rank_update #(
  parameter int w_bitlength     = 12,
  parameter int class_bitlength = 4
) (
  input  logic [w_bitlength-1:0]     v,
  input  logic [class_bitlength-1:0] idx,
  input  logic [w_bitlength-1:0]     best,
  input  logic [w_bitlength-1:0]     second,
  input  logic [class_bitlength-1:0] best_idx,
  output logic [w_bitlength-1:0]     next_best,
  output logic [w_bitlength-1:0]     next_second,
  output logic [class_bitlength-1:0] next_best_idx
);

  always_comb begin
    next_best     = best;
    next_second   = second;
    next_best_idx = best_idx;
    if (v > best) begin
      next_second   = best;
      next_best     = v;
      next_best_idx = idx;
    end else if (v > second) begin
      next_second = v;
    end
  end

endmodule

// File: rtl/vote_argmax.sv
// Sequential arg-max over the RBM wrapper's per-class vote counters, one class
// per cycle, with the winner/count/margin held behind a valid/ready handshake.
module vote_argmax
  import vote_argmax_pkg::*;
#(
  parameter int output_dim      = VA_OUTPUT_DIM,
  parameter int w_bitlength     = VA_W_BITLENGTH,
  parameter int class_bitlength = VA_CLASS_BITLENGTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       vote_valid,
  input  `PORT_1D(VoteData, output_dim, w_bitlength),
  input  logic                       result_ready,
  output logic                       result_valid,
  output logic [class_bitlength-1:0] result_class,
  output logic [w_bitlength-1:0]     result_votes,
  output logic [w_bitlength-1:0]     result_margin,
  output logic                       busy,
  output logic                       sample_dropped
);

  localparam logic [class_bitlength-1:0] last_idx = class_bitlength'(output_dim - 1);

  va_state_t                  state;
  `PORT_1D(vote_buf, output_dim, w_bitlength);
  logic [class_bitlength-1:0] idx;
  logic [w_bitlength-1:0]     best;
  logic [w_bitlength-1:0]     second;
  logic [class_bitlength-1:0] best_idx;
  logic                       vote_valid_d;
  logic                       start;
  logic [w_bitlength-1:0]     next_best;
  logic [w_bitlength-1:0]     next_second;
  logic [class_bitlength-1:0] next_best_idx;

  // vote_valid_d clears on reset, so a level still high afterwards re-triggers.
  assign start = vote_valid && !vote_valid_d;
  assign busy  = (state != VA_IDLE);

  vote_rank_update #(
    .w_bitlength    (w_bitlength),
    .class_bitlength(class_bitlength)
  ) u_rank (
    .v            (`GET_1D(vote_buf, idx, w_bitlength)),
    .idx          (idx),
    .best         (best),
    .second       (second),
    .best_idx     (best_idx),
    .next_best    (next_best),
    .next_second  (next_second),
    .next_best_idx(next_best_idx)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= VA_IDLE;
      vote_buf       <= '0;
      idx            <= '0;
      best           <= '0;
      second         <= '0;
      best_idx       <= '0;
      vote_valid_d   <= 1'b0;
      result_valid   <= 1'b0;
      result_class   <= '0;
      result_votes   <= '0;
      result_margin  <= '0;
      sample_dropped <= 1'b0;
    end else begin
      vote_valid_d <= vote_valid;
      if (start && state != VA_IDLE) begin
        sample_dropped <= 1'b1;
      end
      case (state)
        VA_IDLE: begin
          if (start) begin
            vote_buf <= VoteData;
            idx      <= '0;
            best     <= '0;
            second   <= '0;
            best_idx <= '0;
            state    <= VA_SCAN;
          end
        end
        VA_SCAN: begin
          best     <= next_best;
          second   <= next_second;
          best_idx <= next_best_idx;
          idx      <= idx + 1'b1;
          // Results come straight from the update of the last counter.
          if (idx == last_idx) begin
            result_valid  <= 1'b1;
            result_class  <= next_best_idx;
            result_votes  <= next_best;
            result_margin <= next_best - next_second;
            state         <= VA_HOLD;
          end
        end
        VA_HOLD: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state        <= VA_IDLE;
          end
        end
        default: state <= VA_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vote_argmax.sv
// Directed self-checking bench for vote_argmax with hand-computed expectations.
module tb_vote_argmax;

  logic         clock = 1'b0;
  logic         reset;
  logic         vote_valid;
  logic [119:0] VoteData;
  logic         result_ready;
  logic         result_valid;
  logic [3:0]   result_class;
  logic [11:0]  result_votes;
  logic [11:0]  result_margin;
  logic         busy;
  logic         sample_dropped;

  int n_checks = 0;
  int n_fail   = 0;
  int cycles;

  vote_argmax dut (
    .clock         (clock),
    .reset         (reset),
    .vote_valid    (vote_valid),
    .VoteData      (VoteData),
    .result_ready  (result_ready),
    .result_valid  (result_valid),
    .result_class  (result_class),
    .result_votes  (result_votes),
    .result_margin (result_margin),
    .busy          (busy),
    .sample_dropped(sample_dropped)
  );

  always #5 clock = ~clock;

  task automatic applyStimulus(input logic [11:0] v [10]);
    for (int i = 0; i < 10; i++) VoteData[i*12 +: 12] = v[i];
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Counts negedges until result_valid, bounded so a stuck DUT still ends.
  task automatic waitValid(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!result_valid && n < 200);
    if (!result_valid) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL wait_valid: observed timeout after %0d cycles expected result_valid", n);
    end
  endtask

  task automatic checkResult(input string tag, input logic [3:0] cls, input logic [11:0] votes, input logic [11:0] margin);
    checkOutput({tag, "_class"}, 32'(result_class), 32'(cls));
    checkOutput({tag, "_votes"}, 32'(result_votes), 32'(votes));
    checkOutput({tag, "_margin"}, 32'(result_margin), 32'(margin));
  endtask

  task automatic dropVoteValid();
    vote_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset        = 1'b1;
    vote_valid   = 1'b0;
    result_ready = 1'b1;
    VoteData     = '0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("reset_valid", 32'(result_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_dropped", 32'(sample_dropped), 32'd0);
    checkResult("reset", 4'd0, 12'd0, 12'd0);
    reset = 1'b0;
    @(negedge clock);

    // Basic scan, latency and one-cycle pulse.
    applyStimulus('{12'd3, 12'd7, 12'd1, 12'd0, 12'd29, 12'd2, 12'd0, 12'd0, 12'd5, 12'd0});
    vote_valid = 1'b1;
    waitValid(cycles);
    checkOutput("t1_latency", 32'(cycles), 32'd11);
    checkResult("t1", 4'd4, 12'd29, 12'd22);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    @(negedge clock);
    checkOutput("t1_pulse", 32'(result_valid), 32'd0);
    checkOutput("t1_idle", 32'(busy), 32'd0);
    dropVoteValid();

    // Tie between classes 2 and 6.
    applyStimulus('{12'd4, 12'd4, 12'd15, 12'd4, 12'd4, 12'd4, 12'd15, 12'd4, 12'd4, 12'd4});
    vote_valid = 1'b1;
    waitValid(cycles);
    checkResult("t2a", 4'd2, 12'd15, 12'd0);
    dropVoteValid();

    // Tie between first and last class.
    applyStimulus('{12'd30, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd30});
    vote_valid = 1'b1;
    waitValid(cycles);
    checkResult("t2b", 4'd0, 12'd30, 12'd0);
    dropVoteValid();

    // All-zero votes.
    VoteData   = '0;
    vote_valid = 1'b1;
    waitValid(cycles);
    checkOutput("t3_latency", 32'(cycles), 32'd11);
    checkOutput("t3_valid", 32'(result_valid), 32'd1);
    checkResult("t3", 4'd0, 12'd0, 12'd0);
    @(negedge clock);
    dropVoteValid();

    // Backpressure; VoteData rewritten after the start must not matter.
    result_ready = 1'b0;
    applyStimulus('{12'd10, 12'd10, 12'd10, 12'd480, 12'd10, 12'd500, 12'd10, 12'd10, 12'd10, 12'd10});
    vote_valid = 1'b1;
    @(negedge clock);
    VoteData = '1;
    waitValid(cycles);
    checkResult("t4_first", 4'd5, 12'd500, 12'd20);
    repeat (20) @(negedge clock);
    checkOutput("t4_held_valid", 32'(result_valid), 32'd1);
    checkOutput("t4_held_busy", 32'(busy), 32'd1);
    checkResult("t4_held", 4'd5, 12'd500, 12'd20);
    result_ready = 1'b1;
    @(negedge clock);
    checkOutput("t4_release_valid", 32'(result_valid), 32'd0);
    checkOutput("t4_release_busy", 32'(busy), 32'd0);
    dropVoteValid();

    // Second edge during SCAN is dropped; max-value counter.
    checkOutput("t5_dropped_before", 32'(sample_dropped), 32'd0);
    applyStimulus('{12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd4095, 12'd0, 12'd0});
    vote_valid = 1'b1;
    repeat (3) @(negedge clock);
    vote_valid = 1'b0;
    @(negedge clock);
    vote_valid = 1'b1;
    @(negedge clock);
    checkOutput("t5_dropped", 32'(sample_dropped), 32'd1);
    waitValid(cycles);
    checkResult("t5_max", 4'd7, 12'd4095, 12'd4095);
    @(negedge clock);
    dropVoteValid();
    applyStimulus('{12'd3, 12'd7, 12'd1, 12'd0, 12'd29, 12'd2, 12'd0, 12'd0, 12'd5, 12'd0});
    vote_valid = 1'b1;
    waitValid(cycles);
    checkOutput("t5_latency", 32'(cycles), 32'd11);
    checkResult("t5_after", 4'd4, 12'd29, 12'd22);
    checkOutput("t5_dropped_sticky", 32'(sample_dropped), 32'd1);
    @(negedge clock);
    dropVoteValid();

    // Reset in the middle of a scan, vote_valid held high through it.
    vote_valid = 1'b1;
    repeat (5) @(negedge clock);
    checkOutput("t6_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    checkOutput("t6_rst_valid", 32'(result_valid), 32'd0);
    checkOutput("t6_rst_dropped", 32'(sample_dropped), 32'd0);
    checkResult("t6_rst", 4'd0, 12'd0, 12'd0);
    applyStimulus('{12'd0, 12'd0, 12'd0, 12'd50, 12'd0, 12'd0, 12'd60, 12'd0, 12'd0, 12'd9});
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    waitValid(cycles);
    checkOutput("t6_latency", 32'(cycles), 32'd11);
    checkResult("t6", 4'd6, 12'd60, 12'd10);
    @(negedge clock);
    checkOutput("t6_pulse", 32'(result_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
